// File: rtl/yp_fifo_rd_stream_if.sv
// Signal bundle between the FIFO read port, the read-stream adapter and the
// downstream valid/ready consumer.
interface yp_fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    logic                  o_fifo_rd_en;
    logic                  i_fifo_empty;
    logic [DATA_WIDTH-1:0] i_fifo_data;
    logic                  i_flush;
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  i_ready;
    logic [1:0]            o_occupancy;
    logic [CNT_WIDTH-1:0]  o_xfer_cnt;

    // Adapter side
    modport master (
        output o_fifo_rd_en,
        output o_valid,
        output o_data,
        output o_occupancy,
        output o_xfer_cnt,
        input  i_fifo_empty,
        input  i_fifo_data,
        input  i_flush,
        input  i_ready
    );

    // FIFO + consumer side
    modport slave (
        input  o_fifo_rd_en,
        input  o_valid,
        input  o_data,
        input  o_occupancy,
        input  o_xfer_cnt,
        output i_fifo_empty,
        output i_fifo_data,
        output i_flush,
        output i_ready
    );
endinterface

// File: rtl/yp_fifo_rd_stream.sv
// Read-side adapter: turns the FIFO rd_en/empty/registered-data port into a
// valid/ready stream through a 2-entry skid buffer.
module yp_fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    yp_fifo_rd_stream_if.master  bus
);
    localparam int DEPTH = 2;

    logic [1:0]            count_q, count_d;
    logic                  pend_q, pend_d;
    logic [DATA_WIDTH-1:0] buf_q [DEPTH];
    logic [DATA_WIDTH-1:0] buf_d [DEPTH];
    logic [CNT_WIDTH-1:0]  xfer_q, xfer_d;

    logic       pop;
    logic       rd_ok;
    logic       issue;
    logic       land;
    logic [2:0] committed;
    logic [1:0] keep_cnt;

    assign pop = (count_q != 2'd0) & bus.i_ready;

    // Words already owned by the adapter after this cycle's pop; a new read is
    // only allowed while that leaves room for the word it will return.
    assign committed = {1'b0, count_q} + {2'b00, pend_q} - {2'b00, pop};
    assign rd_ok     = ~bus.i_fifo_empty & ~bus.i_flush & (committed < 3'd2);
    assign issue     = rd_ok;

    assign bus.o_fifo_rd_en = i_rstn & rd_ok;

    assign land     = pend_q & ~bus.i_flush;
    assign keep_cnt = count_q - {1'b0, pop};

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] shifted;
            if (gi < DEPTH - 1) begin : g_shift
                assign shifted = pop ? buf_q[gi+1] : buf_q[gi];
            end else begin : g_tail
                assign shifted = buf_q[gi];
            end
            // Arriving word lands right behind whatever survives the pop.
            assign buf_d[gi] = (land && (keep_cnt == 2'(gi))) ? bus.i_fifo_data : shifted;
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        pend_d  = 1'b0;
        xfer_d  = xfer_q;
        if (pop) begin
            xfer_d = xfer_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
        if (bus.i_flush) begin
            count_d = 2'd0;
            pend_d  = 1'b0;
        end else begin
            count_d = count_q - {1'b0, pop} + {1'b0, pend_q};
            pend_d  = issue;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            count_q <= 2'd0;
            pend_q  <= 1'b0;
            xfer_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            pend_q  <= pend_d;
            xfer_q  <= xfer_d;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign bus.o_valid     = (count_q != 2'd0);
    assign bus.o_data      = buf_q[0];
    assign bus.o_occupancy = count_q;
    assign bus.o_xfer_cnt  = xfer_q;
endmodule

// File: tb/tb_yp_fifo_rd_stream.sv
// Self-checking bench for yp_fifo_rd_stream: behavioural FIFO, in-flight word
// queue as reference model, table-driven burst plus directed corner cases.
module tb_yp_fifo_rd_stream;
    localparam int DW = 8;
    localparam int CW = 4;

    logic i_clk;
    logic i_rstn;

    yp_fifo_rd_stream_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    yp_fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .bus    (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural FIFO: data registered one cycle after an accepted read.
    logic [DW-1:0] fifo_q[$];
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;

    assign bus.i_fifo_empty = fifo_empty;
    assign bus.i_fifo_data  = fifo_data;

    always @(posedge i_clk) begin
        if (bus.o_fifo_rd_en && !fifo_empty) begin
            fifo_data  <= fifo_q.pop_front();
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // Reference model: every word read from the FIFO and not yet delivered,
    // oldest first; the newest one is still in flight when pend_m is set.
    logic [DW-1:0] adapt_q[$];
    logic          pend_m;
    int            xfer_m;
    int            delivered;
    int            rd_seen;
    int            occ_m;
    logic          pop_m;
    logic          rd_m;

    always @(negedge i_clk) begin
        if (!i_rstn) begin
            adapt_q.delete();
            pend_m = 1'b0;
            xfer_m = 0;
        end else begin
            occ_m = adapt_q.size() - (pend_m ? 1 : 0);
            pop_m = (occ_m != 0) && bus.i_ready;
            rd_m  = !fifo_empty && !bus.i_flush && ((adapt_q.size() - (pop_m ? 1 : 0)) < 2);
            chk("occupancy", 32'(bus.o_occupancy), 32'(occ_m));
            chk("valid", 32'(bus.o_valid), 32'(occ_m != 0));
            chk("rd_en", 32'(bus.o_fifo_rd_en), 32'(rd_m));
            chk("xfer_cnt", 32'(bus.o_xfer_cnt), 32'(xfer_m % (1 << CW)));
            if (bus.o_fifo_rd_en) rd_seen++;
            if (pop_m) begin
                chk("data_order", 32'(bus.o_data), 32'(adapt_q[0]));
                void'(adapt_q.pop_front());
                xfer_m++;
                delivered++;
            end
            if (bus.i_flush) begin
                adapt_q.delete();
                pend_m = 1'b0;
            end else begin
                pend_m = rd_m;
                if (rd_m) adapt_q.push_back(fifo_q[0]);
            end
        end
    end

    typedef struct {
        logic          ready;
        logic          exp_rd_en;
        logic          exp_valid;
        logic [1:0]    exp_occ;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t tbl [11];

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drain();
        bus.i_ready = 1'b1;
        for (int c = 0; c < 300; c++) begin
            next_cycle();
            if (fifo_q.size() == 0 && adapt_q.size() == 0 && !bus.o_valid) return;
        end
        chk("drain_timeout", 32'(adapt_q.size() + fifo_q.size()), 32'd0);
    endtask

    int base;
    int pushed;
    int seen;

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h00};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 2'd1, 8'h10};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 2'd1, 8'h11};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 2'd1, 8'h12};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 2'd1, 8'h13};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 2'd1, 8'h14};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 2'd1, 8'h15};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 2'd1, 8'h16};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 2'd1, 8'h17};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h00};

        i_rstn      = 1'b0;
        bus.i_flush = 1'b0;
        bus.i_ready = 1'b0;
        fifo_empty  = 1'b1;
        fifo_data   = '0;
        delivered   = 0;
        rd_seen     = 0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_valid", 32'(bus.o_valid), 32'd0);
        chk("reset_data", 32'(bus.o_data), 32'd0);
        chk("reset_rd_en", 32'(bus.o_fifo_rd_en), 32'd0);
        i_rstn = 1'b1;

        // Idle with an empty FIFO.
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            chk("idle_rd_en", 32'(bus.o_fifo_rd_en), 32'd0);
            chk("idle_valid", 32'(bus.o_valid), 32'd0);
            chk("idle_occ", 32'(bus.o_occupancy), 32'd0);
            chk("idle_xfer", 32'(bus.o_xfer_cnt), 32'd0);
        end

        // Table-driven burst of 0x10..0x17 with ready high.
        for (int w = 0; w < 8; w++) push_word(8'(8'h10 + w));
        for (int i = 0; i < 11; i++) begin
            bus.i_ready = tbl[i].ready;
            @(negedge i_clk);
            chk("burst_rd_en", 32'(bus.o_fifo_rd_en), 32'(tbl[i].exp_rd_en));
            chk("burst_valid", 32'(bus.o_valid), 32'(tbl[i].exp_valid));
            chk("burst_occ", 32'(bus.o_occupancy), 32'(tbl[i].exp_occ));
            if (tbl[i].exp_valid) chk("burst_data", 32'(bus.o_data), 32'(tbl[i].exp_data));
            next_cycle();
        end
        chk("burst_xfer", 32'(bus.o_xfer_cnt), 32'd8);

        // Backpressure: only two reads may be issued while ready is low.
        bus.i_ready = 1'b0;
        base = rd_seen;
        for (int w = 0; w < 5; w++) push_word(8'(8'h40 + w));
        repeat (6) next_cycle();
        chk("bp_reads", 32'(rd_seen - base), 32'd2);
        chk("bp_occ", 32'(bus.o_occupancy), 32'd2);
        chk("bp_head", 32'(bus.o_data), 32'h40);
        repeat (3) next_cycle();
        chk("bp_head_stable", 32'(bus.o_data), 32'h40);
        base = delivered;
        drain();
        chk("bp_delivered", 32'(delivered - base), 32'd5);

        // Random fill and random ready over 1000 words.
        base   = delivered;
        pushed = 0;
        for (int c = 0; c < 20000; c++) begin
            next_cycle();
            if (pushed < 1000 && $urandom_range(0, 99) < 60) begin
                for (int k = 0; k < int'($urandom_range(1, 3)) && pushed < 1000; k++) begin
                    push_word(8'($urandom));
                    pushed++;
                end
            end
            bus.i_ready = 1'($urandom_range(0, 1));
            if (delivered - base == 1000) break;
        end
        chk("rand_delivered", 32'(delivered - base), 32'd1000);
        drain();

        // Flush while one word is buffered and one is in flight.
        bus.i_ready = 1'b0;
        push_word(8'hA1);
        push_word(8'hB2);
        push_word(8'hC3);
        next_cycle();
        next_cycle();
        chk("flush_pre_occ", 32'(bus.o_occupancy), 32'd1);
        chk("flush_pre_head", 32'(bus.o_data), 32'hA1);
        bus.i_flush = 1'b1;
        next_cycle();
        bus.i_flush = 1'b0;
        chk("flush_valid", 32'(bus.o_valid), 32'd0);
        chk("flush_occ", 32'(bus.o_occupancy), 32'd0);
        bus.i_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            next_cycle();
            if (bus.o_valid) begin
                chk("flush_next_word", 32'(bus.o_data), 32'hC3);
                seen = 1;
            end
        end
        chk("flush_next_seen", 32'(seen), 32'd1);
        drain();

        // Counter wrap: 17 transfers from reset on a 4-bit counter.
        next_cycle();
        i_rstn = 1'b0;
        next_cycle();
        i_rstn = 1'b1;
        base = delivered;
        for (int w = 0; w < 17; w++) push_word(8'(8'h60 + w));
        drain();
        chk("wrap_delivered", 32'(delivered - base), 32'd17);
        chk("wrap_xfer", 32'(bus.o_xfer_cnt), 32'd1);

        // Asynchronous reset in the middle of a burst.
        for (int w = 0; w < 6; w++) push_word(8'(8'h80 + w));
        bus.i_ready = 1'b1;
        repeat (4) next_cycle();
        #1;
        i_rstn = 1'b0;
        #1;
        chk("arst_rd_en", 32'(bus.o_fifo_rd_en), 32'd0);
        chk("arst_valid", 32'(bus.o_valid), 32'd0);
        chk("arst_data", 32'(bus.o_data), 32'd0);
        chk("arst_occ", 32'(bus.o_occupancy), 32'd0);
        chk("arst_xfer", 32'(bus.o_xfer_cnt), 32'd0);
        next_cycle();
        i_rstn = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/yp_fifo_rd_stream.md
Name: yp_fifo_rd_stream

Overview:
- Read-side adapter for the team's synchronous FIFO.
- Converts the FIFO read interface (rd_en / empty / registered data one cycle after rd_en) into a valid/ready stream.
- Holds up to 2 words in an internal skid buffer, so a consumer with ready held high receives one word per cycle.
- Sits between a FIFO instance and any downstream stream consumer, on the same clock and reset as the FIFO.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and stream data.
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rstn  input  1  asynchronous active-low reset.
- o_fifo_rd_en  output  1  read request to the FIFO; combinational.
- i_fifo_empty  input  1  FIFO empty flag.
- i_fifo_data  input  DATA_WIDTH  FIFO read data; valid in the cycle after a cycle with o_fifo_rd_en=1 and i_fifo_empty=0.
- i_flush  input  1  synchronous discard of buffered and in-flight words.
- o_valid  output  1  stream data valid.
- o_data  output  DATA_WIDTH  stream data (head of the skid buffer).
- i_ready  input  1  consumer ready.
- o_occupancy  output  2  words held in the skid buffer (0..2).
- o_xfer_cnt  output  CNT_WIDTH  count of accepted stream transfers; wraps.

Behaviour:
- Reset, asynchronous on i_rstn low: buffer emptied, pend=0, o_valid=0, o_data=0, o_occupancy=0, o_xfer_cnt=0. o_fifo_rd_en is forced 0 while i_rstn=0.
- State:
  - count in {0,1,2}: number of buffer entries.
  - pend: 1 when a FIFO read was issued last cycle and its data arrives this cycle.
  - The buffer is a 2-entry in-order queue; the head is entry 0.
- Definitions:
  - pop = o_valid & i_ready.
  - issue = o_fifo_rd_en & ~i_fifo_empty.
- Read issue: o_fifo_rd_en = ~i_fifo_empty & ~i_flush & ((count + pend - pop) < 2).
  - This creates a combinational path from i_ready to o_fifo_rd_en; it is accepted.
  - The rule guarantees the buffer never overflows.
- Each edge:
  - pend <= issue.
  - If pend=1, i_fifo_data is appended to the buffer. If pop happens in the same cycle, the head is removed first and the new word lands behind the remaining entry.
  - Next count = count - pop + pend.
- Outputs:
  - o_valid = (count != 0).
  - o_data = head entry; o_data holds its value when o_valid=0.
  - o_occupancy = count.
- Stream rule: while o_valid=1 and i_ready=0, o_data and o_valid are stable.
- Latency: FIFO non-empty with an idle adapter → o_fifo_rd_en=1 in cycle 0 → o_valid=1 in cycle 2.
- Throughput: with i_ready held 1 and the FIFO non-empty, one transfer per cycle in steady state (count=1, pend=1).
- Counter: o_xfer_cnt increments by 1 on each pop and wraps from 2^CNT_WIDTH-1 to 0.
- Flush (i_flush=1 at an edge):
  - count <= 0 and o_fifo_rd_en=0 that cycle.
  - A pop in the flush cycle still counts.
  - Data arriving for a pend set before the flush is dropped; pend <= 0.
  - o_xfer_cnt is not cleared.
- FIFO empties mid-burst: buffered words drain normally; o_valid drops when count reaches 0.
- Reset mid-operation: all buffered and in-flight words are lost, with no output glitch beyond the forced zeros.

Test Plan:
- Reset then idle: i_fifo_empty=1 → o_fifo_rd_en=0, o_valid=0, o_occupancy=0, o_xfer_cnt=0 for 10 cycles.
- Burst with ready=1: FIFO preloaded with 0x10..0x17 → o_fifo_rd_en high for 8 consecutive cycles; o_valid first high 2 cycles after the first rd_en; o_data=0x10..0x17 on 8 consecutive cycles; o_xfer_cnt=8.
- Backpressure: 5 words in the FIFO, i_ready=0 → exactly 2 reads issued, o_occupancy=2, o_data=head word stable. Release i_ready → remaining words delivered in order, none lost or duplicated.
- Random i_ready (50%) over 1000 words with random FIFO fill → output sequence equals input sequence; o_xfer_cnt=1000.
- Flush with pend=1 and count=1 → next cycle o_valid=0, o_occupancy=0; the in-flight word never appears on o_data; the next word delivered is the following FIFO entry.
- Counter wrap with CNT_WIDTH=4: 17 transfers → o_xfer_cnt=1. Reset asserted mid-burst → all outputs 0 immediately (asynchronous), o_fifo_rd_en=0.
